// File: rtl/mul_iter.sv
// Iterative radix-2^STEP multiplier for MUL/MULH/MULHSU/MULHU: operands are
// converted to magnitudes, accumulated STEP bits per cycle, then re-signed.
module mul_iter #(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready depends only on state and rst, and out_valid
    // with result stays stable until out_ready is seen.

    localparam int N    = XLEN / STEP;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int PW   = 2 * XLEN;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            out_valid_q, out_valid_d;

    logic            accept;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   product;

    assign accept = (state_q == S_IDLE) && in_valid && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) state_d = S_BUSY;
                S_BUSY: if (cnt_q == LAST) state_d = S_FIX;
                S_FIX:  state_d = S_DONE;
                S_DONE: if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The multiplicand is pre-shifted each cycle so only constant shifts remain.
    always_comb begin
        pp = '0;
        for (int i = 0; i < STEP; i++) begin
            if (mplier_q[i]) pp = pp + (mcand_q << i);
        end
    end

    assign product = (sa_q ^ sb_q) ? (~acc_q + PW'(1)) : acc_q;

    always_comb begin
        op_d        = op_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            op_d     = op;
            sa_d     = ((op == 2'b01) || (op == 2'b10)) && a[XLEN-1];
            sb_d     = (op == 2'b01) && b[XLEN-1];
            mcand_d  = {{XLEN{1'b0}}, (sa_d ? (~a + XLEN'(1)) : a)};
            mplier_d = sb_d ? (~b + XLEN'(1)) : b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == S_BUSY) begin
            acc_d    = acc_q + pp;
            mcand_d  = mcand_q << STEP;
            mplier_d = mplier_q >> STEP;
            cnt_d    = cnt_q + CW'(1);
        end else if (state_q == S_FIX) begin
            result_d    = (op_q == 2'b00) ? product[XLEN-1:0] : product[PW-1:XLEN];
            out_valid_d = 1'b1;
        end else if ((state_q == S_DONE) && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = out_valid_q;
        result    = result_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed RISC-V corner cases, handshake,
// flush and reset scenarios, then randomized operations against a signed-arithmetic model.
module tb_mul_iter;

  localparam int XLEN = 32;
  localparam int STEP = 4;
  localparam int N    = XLEN / STEP;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_res = '0;

  mul_iter #(.XLEN(XLEN), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference: full signed/unsigned product in a wide signed container
  function automatic logic [XLEN-1:0] model(input logic [1:0] mop, input logic [XLEN-1:0] ma,
                                             input logic [XLEN-1:0] mb);
    logic signed [2*XLEN+1:0] ea, eb, p;
    ea = (mop == 2'b01 || mop == 2'b10) ? {{(XLEN+2){ma[XLEN-1]}}, ma} : {{(XLEN+2){1'b0}}, ma};
    eb = (mop == 2'b01) ? {{(XLEN+2){mb[XLEN-1]}}, mb} : {{(XLEN+2){1'b0}}, mb};
    p = ea * eb;
    return (mop == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] pick();
    logic [XLEN-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = XLEN'(1);
      2: v = {1'b1, {(XLEN-1){1'b0}}};
      3: v = '1;
      default: v = XLEN'($urandom);
    endcase
    return v;
  endfunction

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", XLEN'(in_ready), XLEN'(1));
  endtask

  task automatic start(input logic [1:0] sop, input logic [XLEN-1:0] sa, input logic [XLEN-1:0] sb);
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    op = sop;
    a = sa;
    b = sb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 2'($urandom);
    a = XLEN'($urandom);
    b = XLEN'($urandom);
  endtask

  task automatic collect(input int stall);
    int lat = 0;
    logic [XLEN-1:0] exp;
    while (!out_valid && lat < 4 * N + 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", XLEN'(lat), XLEN'(N + 1));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_result", result, exp_q[0]);
      check("hold_in_ready", XLEN'(in_ready), XLEN'(0));
      check("hold_out_valid", XLEN'(out_valid), XLEN'(1));
    end
    @(negedge clk);
    out_ready = 1'b1;
    exp = exp_q.pop_front();
    check("result", result, exp);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_out_valid", XLEN'(out_valid), XLEN'(0));
    check("post_in_ready", XLEN'(in_ready), XLEN'(1));
    last_res = exp;
  endtask

  task automatic run(input logic [1:0] rop, input logic [XLEN-1:0] ra, input logic [XLEN-1:0] rb,
                     input logic [XLEN-1:0] exp, input int stall);
    start(rop, ra, rb);
    exp_q.push_back(exp);
    collect(stall);
  endtask

  task automatic run_model(input logic [1:0] rop, input logic [XLEN-1:0] ra, input logic [XLEN-1:0] rb,
                           input int stall);
    run(rop, ra, rb, model(rop, ra, rb), stall);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check(tag, XLEN'(seen), XLEN'(0));
  endtask

  initial begin
    // reset
    repeat (2) @(negedge clk);
    check("rst_in_ready", XLEN'(in_ready), XLEN'(0));
    check("rst_out_valid", XLEN'(out_valid), XLEN'(0));
    check("rst_result", result, '0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", XLEN'(in_ready), XLEN'(1));

    // directed corner cases
    run(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5);
    run(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 2);

    // flush in the third BUSY cycle
    start(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_in_ready", XLEN'(in_ready), XLEN'(1));
    check("flush_out_valid", XLEN'(out_valid), XLEN'(0));
    check("flush_result_kept", result, last_res);
    watch_no_valid("flush_no_valid", N + 3);
    run(2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0);

    // flush wins over in_valid in IDLE
    @(negedge clk);
    in_valid = 1'b1;
    flush = 1'b1;
    op = 2'b00;
    a = 32'd5;
    b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_in_ready", XLEN'(in_ready), XLEN'(1));
    watch_no_valid("flush_idle_no_valid", N + 3);

    // reset mid-BUSY
    start(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", XLEN'(out_valid), XLEN'(0));
    check("midrst_result", result, '0);
    check("midrst_in_ready", XLEN'(in_ready), XLEN'(0));
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready_held", XLEN'(in_ready), XLEN'(0));
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", XLEN'(in_ready), XLEN'(1));
    last_res = '0;
    run_model(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0);

    // randomized sweep per op
    for (int o = 0; o < 4; o++) begin
      for (int k = 0; k < 250; k++) begin
        run_model(2'(o), pick(), pick(), $urandom_range(0, 2));
      end
    end

    // final report
    check("scoreboard_empty", XLEN'(exp_q.size()), XLEN'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_iter.md
# mul_iter

Parametrised iterative integer multiplier for the core's M-extension execute path; successor to the single-cycle combinational 32x32 multiplier. It takes operands through a valid/ready handshake and retires STEP multiplier bits per clock. It supports all four RISC-V multiply variants (MUL, MULH, MULHSU, MULHU) and returns the selected XLEN-bit half through a second valid/ready handshake. A synchronous flush discards an in-flight operation on pipeline kill.

## Interface
- XLEN, 32: operand and result width; even, >= 8.
- STEP, 4: multiplier bits consumed per BUSY cycle; must divide XLEN; N = XLEN/STEP.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept; high only in IDLE and low while rst is high.
- op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (equals funct3[1:0]).
- a  input  XLEN  multiplicand (rs1).
- b  input  XLEN  multiplier (rs2).
- flush  input  1  abort the current operation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  selected product half.

## Operation
- States: IDLE, BUSY, FIX, DONE. Reset forces IDLE asynchronously. Reset values: out_valid=0, result=0, all internal registers cleared.
- IDLE: in_ready=1. On the in_valid edge with flush=0:
  - latch op;
  - latch the sign flags: sa = op∈{01,10} & a[XLEN-1], sb = (op==01) & b[XLEN-1];
  - latch magnitudes |a|, |b| (two's-complement negate when the flag is set); the most negative value maps to 2^(XLEN-1) unsigned;
  - clear the 2*XLEN accumulator and the iteration counter, then go to BUSY.
- BUSY: each cycle, acc += |a| * mplier[STEP-1:0] << (STEP*count); the multiplier shifts right by STEP and count increments. After count reaches N-1, go to FIX.
- FIX: if sa^sb, product = -acc (mod 2^(2*XLEN)); otherwise product = acc. result is loaded with product[XLEN-1:0] for op=00, else product[2*XLEN-1:XLEN]. out_valid is set and the state goes to DONE.
- DONE: result and out_valid are held stable until out_ready=1. On that edge out_valid clears and the state returns to IDLE. A new operation is not accepted in that same cycle, because in_ready is low in DONE.
- MUL low half is sign-independent; for op=00 both sign flags are 0.
- flush=1 in any state: the next edge goes to IDLE with out_valid=0. result keeps its old value, and no result is produced for the flushed operation. In IDLE, flush has priority over in_valid, so nothing is accepted.
- in_valid outside IDLE is ignored. Operand inputs are sampled only on the accept edge.

## Timing
- Accept at edge E0.
- BUSY occupies edges E1..EN; FIX loads result at edge EN+1.
- out_valid is first high after edge EN+1. Latency is N+1 cycles (9 for the defaults).
- Minimum issue interval is N+3 cycles: accept, N BUSY cycles, FIX, one DONE cycle with out_ready high, then IDLE.
- in_ready is combinational from state (and rst) only. There is no combinational path from in_valid, out_ready or flush to any output.
- rst asserted mid-operation:
  - immediately forces IDLE, out_valid=0 and result=0;
  - in_ready stays 0 until rst deasserts;
  - the first accept is possible on the first edge after deassertion.

## Test plan
- Unsigned extremes: a=b=0xFFFFFFFF.
  - MULHU -> 0xFFFFFFFE.
  - MUL -> 0x00000001.
- Signed corner cases:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULH 0xFFFFFFFF*0x00000001 -> 0xFFFFFFFF.
  - MUL 0x80000000*0xFFFFFFFF -> 0x80000000.
- Mixed sign: MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHSU a=0x00000002, b=0x80000000 -> 0x00000001.
- Handshake and latency (defaults): accept at E0 -> out_valid rises after E9.
  - With out_ready held low for 5 cycles, result stays constant and in_ready stays 0.
  - out_ready=1 -> IDLE on the next edge, with in_ready=1.
- Flush: flush at the third BUSY cycle -> IDLE on the next edge and out_valid never rises. An immediately following MULHU 0x00010000*0x00010000 returns 0x00000001. Flush coincident with in_valid in IDLE -> no accept.
- Reset and sweep:
  - rst pulsed mid-BUSY -> out_valid=0 and result=0 immediately, and the next operation is correct.
  - Random 10k operations per op against a golden model, repeated for STEP=1, 2, 8 and XLEN=16 -> zero mismatches.
